// File: rtl/frec_div_pkg.sv
// Shared types and constants for the multi-channel clock divider.
package frec_div_pkg;

   localparam int unsigned CH_W = 4;

   typedef enum logic {
      MODE_TOGGLE = 1'b0,
      MODE_PULSE  = 1'b1
   } mode_e;

endpackage

// File: rtl/frec_div_multi_if.sv
// Configuration bus of the multi-channel divider: write port, error flag, pending flags.
interface frec_div_multi_if #(
   parameter int unsigned NCH   = 4,
   parameter int unsigned WIDTH = 16
);
   import frec_div_pkg::*;

   logic              cfg_wr;
   logic [CH_W-1:0]   cfg_ch;
   logic [WIDTH-1:0]  cfg_div;
   mode_e             cfg_mode;
   logic              cfg_err;
   logic [NCH-1:0]    pending;

   modport master (
      output cfg_wr, cfg_ch, cfg_div, cfg_mode,
      input  cfg_err, pending
   );

   modport slave (
      input  cfg_wr, cfg_ch, cfg_div, cfg_mode,
      output cfg_err, pending
   );

endinterface

// File: rtl/frec_div_chan.sv
// One divider channel: counter, shadow/active config, glitch-free apply, registered outputs.
module frec_div_chan
   import frec_div_pkg::*;
#(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned DEF_DIV = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             wr,
   input  logic [WIDTH-1:0] wr_div,
   input  mode_e            wr_mode,
   output logic             pending,
   output logic             tick,
   output logic             nfrec
);

   typedef struct packed {
      logic [WIDTH-1:0] div;
      mode_e            mode;
   } cfg_t;

   localparam cfg_t DefCfg = '{div: WIDTH'(DEF_DIV), mode: MODE_TOGGLE};

   cfg_t             shadow_q, shadow_d, active_q, active_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tog_q, tog_d;
   logic             pending_q, pending_d;
   logic             tick_q, tick_d;
   logic             nfrec_q, nfrec_d;
   logic             term, apply;

   always_comb begin
      term      = en && (cnt_q == active_q.div);
      // Active config only changes on a period boundary or while idle.
      apply     = term || !en;
      active_d  = apply ? shadow_q : active_q;
      shadow_d  = shadow_q;
      pending_d = apply ? 1'b0 : pending_q;
      if (wr) begin
         shadow_d  = '{div: wr_div, mode: wr_mode};
         pending_d = 1'b1;
      end
      cnt_d = (!en || term) ? '0 : cnt_q + WIDTH'(1);
      tog_d = tog_q;
      if (!en || active_d.mode == MODE_PULSE) begin
         tog_d = 1'b0;
      end else if (term) begin
         tog_d = ~tog_q;
      end
      tick_d  = term;
      nfrec_d = (active_d.mode == MODE_PULSE) ? term : tog_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q  <= DefCfg;
         active_q  <= DefCfg;
         cnt_q     <= '0;
         tog_q     <= 1'b0;
         pending_q <= 1'b0;
         tick_q    <= 1'b0;
         nfrec_q   <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         cnt_q     <= cnt_d;
         tog_q     <= tog_d;
         pending_q <= pending_d;
         tick_q    <= tick_d;
         nfrec_q   <= nfrec_d;
      end
   end

   assign pending = pending_q;
   assign tick    = tick_q;
   assign nfrec   = nfrec_q;

endmodule

// File: rtl/frec_div_multi.sv
// Multi-channel programmable clock divider: config decode, error flag, channel array.
module frec_div_multi
   import frec_div_pkg::*;
#(
   parameter int unsigned NCH     = 4,
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned DEF_DIV = 1
) (
   input  logic              cLocK,
   input  logic              Reset,
   input  logic [NCH-1:0]    en,
   frec_div_multi_if.slave   cfg,
   output logic [NCH-1:0]    tick,
   output logic [NCH-1:0]    NFrec
);

   logic           err_q;
   logic [NCH-1:0] pend;

   always_ff @(posedge cLocK) begin
      if (Reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= cfg.cfg_wr && (32'(cfg.cfg_ch) >= NCH);
      end
   end

   assign cfg.cfg_err = err_q;
   assign cfg.pending = pend;

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      logic sel;
      assign sel = cfg.cfg_wr && (cfg.cfg_ch == CH_W'(i));

      frec_div_chan #(
         .WIDTH   (WIDTH),
         .DEF_DIV (DEF_DIV)
      ) u_chan (
         .clk     (cLocK),
         .rst     (Reset),
         .en      (en[i]),
         .wr      (sel),
         .wr_div  (cfg.cfg_div),
         .wr_mode (cfg.cfg_mode),
         .pending (pend[i]),
         .tick    (tick[i]),
         .nfrec   (NFrec[i])
      );
   end

endmodule

// File: tb/tb_frec_div_multi.sv
// Directed plus randomized bench for frec_div_multi against a cycle-level behavioural model.
module tb_frec_div_multi;
   import frec_div_pkg::*;

   localparam int unsigned NCH     = 4;
   localparam int unsigned WIDTH   = 8;
   localparam int unsigned DEF_DIV = 1;

   logic           cLocK = 1'b0;
   logic           Reset;
   logic [NCH-1:0] en;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] NFrec;

   frec_div_multi_if #(.NCH(NCH), .WIDTH(WIDTH)) cfg_bus ();

   frec_div_multi #(
      .NCH     (NCH),
      .WIDTH   (WIDTH),
      .DEF_DIV (DEF_DIV)
   ) dut (
      .cLocK (cLocK),
      .Reset (Reset),
      .en    (en),
      .cfg   (cfg_bus.slave),
      .tick  (tick),
      .NFrec (NFrec)
   );

   always #5 cLocK = ~cLocK;

   int checks   = 0;
   int failures = 0;

   // Reference state: counter position, divisors, modes, pending flags, expected outputs.
   int m_cnt  [NCH];
   int m_div  [NCH];
   int m_sdiv [NCH];
   bit m_mode [NCH];
   bit m_smode[NCH];
   bit m_pend [NCH];
   bit m_tog  [NCH];
   bit m_tick [NCH];
   bit m_nf   [NCH];
   bit m_err;

   task automatic model_step();
      if (Reset) begin
         for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_div[c] = DEF_DIV; m_sdiv[c] = DEF_DIV;
            m_mode[c] = 0; m_smode[c] = 0; m_pend[c] = 0;
            m_tog[c] = 0; m_tick[c] = 0; m_nf[c] = 0;
         end
         m_err = 0;
      end else begin
         m_err = cfg_bus.cfg_wr && (int'(cfg_bus.cfg_ch) >= NCH);
         for (int c = 0; c < NCH; c++) begin
            bit run, tc, w;
            run = en[c];
            tc  = run && (m_cnt[c] == m_div[c]);
            w   = cfg_bus.cfg_wr && (int'(cfg_bus.cfg_ch) == c);
            if (tc || !run) begin
               m_div[c] = m_sdiv[c]; m_mode[c] = m_smode[c]; m_pend[c] = 0;
            end
            if (w) begin
               m_sdiv[c]  = int'(cfg_bus.cfg_div);
               m_smode[c] = (cfg_bus.cfg_mode == MODE_PULSE);
               m_pend[c]  = 1;
            end
            if (!run) begin
               m_cnt[c] = 0; m_tog[c] = 0;
            end else if (tc) begin
               m_cnt[c] = 0; m_tog[c] = !m_tog[c];
            end else begin
               m_cnt[c]++;
            end
            if (m_mode[c]) m_tog[c] = 0;
            m_tick[c] = tc;
            m_nf[c]   = m_mode[c] ? tc : m_tog[c];
         end
      end
   endtask

   task automatic check_all();
      logic [NCH-1:0] et, enf, ep;
      for (int c = 0; c < NCH; c++) begin
         et[c] = m_tick[c]; enf[c] = m_nf[c]; ep[c] = m_pend[c];
      end
      checks++;
      assert (tick === et) else begin
         failures++; $error("FAIL tick obs=%b exp=%b t=%0t", tick, et, $time);
      end
      checks++;
      assert (NFrec === enf) else begin
         failures++; $error("FAIL nfrec obs=%b exp=%b t=%0t", NFrec, enf, $time);
      end
      checks++;
      assert (cfg_bus.pending === ep) else begin
         failures++; $error("FAIL pending obs=%b exp=%b t=%0t", cfg_bus.pending, ep, $time);
      end
      checks++;
      assert (cfg_bus.cfg_err === m_err) else begin
         failures++; $error("FAIL cfg_err obs=%b exp=%b t=%0t", cfg_bus.cfg_err, m_err, $time);
      end
   endtask

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++; $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge cLocK);
      model_step();
      #1;
      check_all();
   endtask

   task automatic write(input int ch, input int div, input bit mode);
      cfg_bus.cfg_wr   = 1'b1;
      cfg_bus.cfg_ch   = CH_W'(ch);
      cfg_bus.cfg_div  = WIDTH'(div);
      cfg_bus.cfg_mode = mode_e'(mode);
      cycle();
      cfg_bus.cfg_wr   = 1'b0;
   endtask

   // Cycles until the next tick on a channel; -1 if the budget runs out.
   task automatic gap_to_tick(input int ch, input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         cycle();
         if (tick[ch]) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic wait_applied(input int ch, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (!cfg_bus.pending[ch]) break;
         cycle();
      end
      check_eq("apply_done", int'(cfg_bus.pending[ch]), 0);
   endtask

   initial begin
      int n;
      Reset            = 1'b1;
      en               = '0;
      cfg_bus.cfg_wr   = 1'b0;
      cfg_bus.cfg_ch   = '0;
      cfg_bus.cfg_div  = '0;
      cfg_bus.cfg_mode = MODE_TOGGLE;
      cycle();
      cycle();
      check_eq("rst_nfrec", int'(NFrec), 0);
      check_eq("rst_pending", int'(cfg_bus.pending), 0);
      Reset = 1'b0;
      en    = '1;

      // Default divisor: tick every 2 cycles, all channels in phase.
      cycle();
      gap_to_tick(0, 4, n);
      gap_to_tick(0, 4, n);
      check_eq("t1_period", n, 2);
      check_eq("t1_phase", int'(NFrec == '0 || NFrec == '1), 1);

      // Retune ch2 to D=4 mid-period.
      cycle();
      write(2, 4, 1'b0);
      check_eq("t2_pending", int'(cfg_bus.pending[2]), 1);
      wait_applied(2, 8);
      gap_to_tick(2, 10, n);
      check_eq("t2_period", n, 5);

      // Write ch1 D=0 pulse on the same edge as its terminal count.
      for (int i = 0; i < 8; i++) begin
         if (m_cnt[1] == m_div[1]) break;
         cycle();
      end
      write(1, 0, 1'b1);
      check_eq("t3_pend_kept", int'(cfg_bus.pending[1]), 1);
      repeat (3) cycle();
      for (int i = 0; i < 4; i++) begin
         cycle();
         check_eq("t3_strobe", int'(NFrec[1]), 1);
      end

      // Out-of-range channel index.
      wait_applied(1, 4);
      write(NCH, 7, 1'b1);
      check_eq("t4_err", int'(cfg_bus.cfg_err), 1);
      check_eq("t4_pend", int'(cfg_bus.pending), 0);
      cycle();
      check_eq("t4_err_clr", int'(cfg_bus.cfg_err), 0);
      gap_to_tick(0, 4, n);
      gap_to_tick(0, 4, n);
      check_eq("t4_ch0_period", n, 2);

      // Disable ch0 for 3 cycles, then restart.
      cycle();
      en[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check_eq("t5_off", int'(NFrec[0]), 0);
      end
      en[0] = 1'b1;
      gap_to_tick(0, 8, n);
      check_eq("t5_restart", n, 2);

      // Maximum divisor on ch3.
      write(3, 255, 1'b0);
      wait_applied(3, 10);
      gap_to_tick(3, 300, n);
      gap_to_tick(3, 300, n);
      check_eq("max_period", n, 256);

      // Randomized enables and writes.
      for (int k = 0; k < 400; k++) begin
         for (int c = 0; c < NCH; c++) en[c] = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 3) == 0) begin
            cfg_bus.cfg_wr   = 1'b1;
            cfg_bus.cfg_ch   = CH_W'($urandom_range(0, 5));
            cfg_bus.cfg_div  = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom_range(200, 255))
                                                          : WIDTH'($urandom_range(0, 6));
            cfg_bus.cfg_mode = mode_e'($urandom_range(0, 1));
         end
         cycle();
         cfg_bus.cfg_wr = 1'b0;
      end

      // Reset with pending writes.
      en = '1;
      write(0, 3, 1'b0);
      write(2, 5, 1'b1);
      Reset = 1'b1;
      cycle();
      check_eq("t6_tick", int'(tick), 0);
      check_eq("t6_nfrec", int'(NFrec), 0);
      check_eq("t6_pending", int'(cfg_bus.pending), 0);
      Reset = 1'b0;
      gap_to_tick(0, 4, n);
      check_eq("t6_first", n, 2);
      gap_to_tick(2, 4, n);
      check_eq("t6_ch2_def", n, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
